// File: rtl/mc_run_sequencer_pkg.sv
// Shared types and default header locations
// for the multi-core matrix processor run sequencer.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_IMEM = 3'd1,
    LOAD_DMEM = 3'd2,
    EXECUTE   = 3'd3,
    TX_DMEM   = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_UART = 2'd1,
    OWN_PROC = 2'd2
  } dmem_owner_t;

  localparam int RX_END_LOC_DEF   = 7;
  localparam int TX_START_LOC_DEF = 5;
  localparam int TX_END_LOC_DEF   = 8;

endpackage

// File: rtl/mc_run_sequencer_if.sv
// Control/status bundle between the run sequencer
// and the UART, memory and processor agents.
interface mc_run_sequencer_if #(
  parameter int REG_WIDTH           = 12,
  parameter int CORE_COUNT          = 3,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int CYCLE_WIDTH         = 26,
  parameter int RUN_CNT_WIDTH       = 8
);

  logic                              start;
  logic                              reload_ins;
  logic                              ins_received;
  logic                              dmem_received;
  logic                              dmem_transmitted;
  logic                              proc_done;
  logic                              uart_dmem_wr_en;
  logic [DATA_MEM_ADDR_WIDTH-1:0]    uart_dmem_addr;
  logic [CORE_COUNT*REG_WIDTH-1:0]   uart_dmem_data;

  logic [2:0]                        state;
  logic [1:0]                        dmem_owner;
  logic                              imem_owner;
  logic                              rx_ins_en;
  logic                              rx_dmem_en;
  logic                              proc_start;
  logic                              tx_startN;
  logic [REG_WIDTH-1:0]              rx_end_addr;
  logic [REG_WIDTH-1:0]              tx_start_addr;
  logic [REG_WIDTH-1:0]              tx_end_addr;
  logic [CYCLE_WIDTH-1:0]            run_cycles;
  logic [RUN_CNT_WIDTH-1:0]          run_count;
  logic                              timeout_err;
  logic                              cfg_err;

  modport master (
    input  start, reload_ins, ins_received,
    input  dmem_received, dmem_transmitted,
    input  proc_done, uart_dmem_wr_en,
    input  uart_dmem_addr, uart_dmem_data,
    output state, dmem_owner, imem_owner,
    output rx_ins_en, rx_dmem_en,
    output proc_start, tx_startN,
    output rx_end_addr, tx_start_addr, tx_end_addr,
    output run_cycles, run_count,
    output timeout_err, cfg_err
  );

  modport slave (
    output start, reload_ins, ins_received,
    output dmem_received, dmem_transmitted,
    output proc_done, uart_dmem_wr_en,
    output uart_dmem_addr, uart_dmem_data,
    input  state, dmem_owner, imem_owner,
    input  rx_ins_en, rx_dmem_en,
    input  proc_start, tx_startN,
    input  rx_end_addr, tx_start_addr, tx_end_addr,
    input  run_cycles, run_count,
    input  timeout_err, cfg_err
  );

endinterface

// File: rtl/mc_exec_watchdog.sv
// Execute-phase cycle counter with saturation
// and an optional timeout compare.
module mc_exec_watchdog #(
  parameter int CYCLE_WIDTH    = 26,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  output logic [CYCLE_WIDTH-1:0] count,
  output logic                   expired
);

  localparam logic [CYCLE_WIDTH-1:0] LIMIT =
    (TIMEOUT_CYCLES == 0) ? '0 :
    CYCLE_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CYCLE_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th execute cycle.
  assign expired = enable && (TIMEOUT_CYCLES != 0) &&
                   (count_q == LIMIT);
  assign count   = count_q;

endmodule

// File: rtl/mc_run_sequencer.sv
// Run controller: load imem/dmem, execute, transmit,
// with re-run, watchdog, window check and statistics.
module mc_run_sequencer
  import mc_seq_pkg::*;
#(
  parameter int REG_WIDTH           = 12,
  parameter int CORE_COUNT          = 3,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int RX_END_LOC          = RX_END_LOC_DEF,
  parameter int TX_START_LOC        = TX_START_LOC_DEF,
  parameter int TX_END_LOC          = TX_END_LOC_DEF,
  parameter int TIMEOUT_CYCLES      = 0,
  parameter int CYCLE_WIDTH         = 26,
  parameter int RUN_CNT_WIDTH       = 8
) (
  input logic                clk,
  input logic                rst,
  mc_run_sequencer_if.master bus
);

  localparam int DW = CORE_COUNT * REG_WIDTH;
  localparam int AW = DATA_MEM_ADDR_WIDTH;

  state_t                   state_q, state_d;
  logic                     ins_valid_q, ins_valid_d;
  logic [REG_WIDTH-1:0]     rx_end_q, rx_end_d;
  logic [REG_WIDTH-1:0]     tx_start_q, tx_start_d;
  logic [REG_WIDTH-1:0]     tx_end_q, tx_end_d;
  logic [RUN_CNT_WIDTH-1:0] run_count_q, run_count_d;
  logic                     timeout_err_q, timeout_err_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     proc_start_q;
  logic                     tx_startn_q;
  logic                     wd_clear, wd_en, wd_expired;
  logic [CYCLE_WIDTH-1:0]   wd_count;
  dmem_owner_t              owner;
  logic [DW-1:0]            unused_data;

  assign unused_data = bus.uart_dmem_data;

  always_comb begin
    rx_end_d   = rx_end_q;
    tx_start_d = tx_start_q;
    tx_end_d   = tx_end_q;
    if (state_q == LOAD_DMEM && bus.uart_dmem_wr_en) begin
      if (bus.uart_dmem_addr == AW'(RX_END_LOC))
        rx_end_d = bus.uart_dmem_data[REG_WIDTH-1:0];
      if (bus.uart_dmem_addr == AW'(TX_START_LOC))
        tx_start_d = bus.uart_dmem_data[REG_WIDTH-1:0];
      if (bus.uart_dmem_addr == AW'(TX_END_LOC))
        tx_end_d = bus.uart_dmem_data[REG_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    ins_valid_d   = ins_valid_q;
    run_count_d   = run_count_q;
    timeout_err_d = timeout_err_q;
    cfg_err_d     = cfg_err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start)
          state_d = (bus.reload_ins || !ins_valid_q) ?
                    LOAD_IMEM : LOAD_DMEM;
      end
      LOAD_IMEM: begin
        if (bus.ins_received) begin
          state_d     = LOAD_DMEM;
          ins_valid_d = 1'b1;
        end
      end
      LOAD_DMEM: begin
        // Window check sees this cycle's header write.
        if (bus.dmem_received) begin
          if (tx_start_d > tx_end_d) begin
            state_d   = ERROR;
            cfg_err_d = 1'b1;
          end else begin
            state_d = EXECUTE;
          end
        end
      end
      EXECUTE: begin
        if (bus.proc_done) begin
          state_d = TX_DMEM;
        end else if (wd_expired) begin
          state_d       = ERROR;
          timeout_err_d = 1'b1;
        end
      end
      TX_DMEM: begin
        if (bus.dmem_transmitted) begin
          state_d     = DONE;
          run_count_d = run_count_q + 1'b1;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  assign wd_en    = (state_q == EXECUTE);
  assign wd_clear = (state_q != EXECUTE) &&
                    (state_d == EXECUTE);

  mc_exec_watchdog #(
    .CYCLE_WIDTH    (CYCLE_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_en),
    .count   (wd_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ins_valid_q   <= 1'b0;
      rx_end_q      <= '0;
      tx_start_q    <= '0;
      tx_end_q      <= '0;
      run_count_q   <= '0;
      timeout_err_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      proc_start_q  <= 1'b0;
      tx_startn_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      ins_valid_q   <= ins_valid_d;
      rx_end_q      <= rx_end_d;
      tx_start_q    <= tx_start_d;
      tx_end_q      <= tx_end_d;
      run_count_q   <= run_count_d;
      timeout_err_q <= timeout_err_d;
      cfg_err_q     <= cfg_err_d;
      proc_start_q  <= wd_clear;
      tx_startn_q   <= !((state_q != TX_DMEM) &&
                         (state_d == TX_DMEM));
    end
  end

  always_comb begin
    owner = OWN_NONE;
    unique case (state_q)
      LOAD_DMEM, TX_DMEM: owner = OWN_UART;
      EXECUTE:            owner = OWN_PROC;
      default:            owner = OWN_NONE;
    endcase
  end

  assign bus.state         = state_q;
  assign bus.dmem_owner    = owner;
  assign bus.imem_owner    = (state_q == LOAD_IMEM);
  assign bus.rx_ins_en     = (state_q == LOAD_IMEM);
  assign bus.rx_dmem_en    = (state_q == LOAD_DMEM);
  assign bus.proc_start    = proc_start_q;
  assign bus.tx_startN     = tx_startn_q;
  assign bus.rx_end_addr   = rx_end_q;
  assign bus.tx_start_addr = tx_start_q;
  assign bus.tx_end_addr   = tx_end_q;
  assign bus.run_cycles    = wd_count;
  assign bus.run_count     = run_count_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_mc_run_sequencer.sv
// Directed + randomized bench for mc_run_sequencer:
// dut0 has no watchdog, dut1 a 50-cycle watchdog.
module tb_mc_run_sequencer;

  localparam int RW = 12;
  localparam int CC = 3;
  localparam int AW = 12;
  localparam int CW = 26;
  localparam int NW = 8;
  localparam int DW = RW * CC;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LIMEM = 3'd1;
  localparam logic [2:0] S_LDMEM = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_TX    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 0, reload_ins = 0;
  logic          ins_received = 0, dmem_received = 0;
  logic          dmem_transmitted = 0, proc_done = 0;
  logic          wr_en = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  mc_run_sequencer_if #(
    .REG_WIDTH(RW), .CORE_COUNT(CC),
    .DATA_MEM_ADDR_WIDTH(AW),
    .CYCLE_WIDTH(CW), .RUN_CNT_WIDTH(NW)
  ) bus0 ();
  mc_run_sequencer_if #(
    .REG_WIDTH(RW), .CORE_COUNT(CC),
    .DATA_MEM_ADDR_WIDTH(AW),
    .CYCLE_WIDTH(CW), .RUN_CNT_WIDTH(NW)
  ) bus1 ();

  mc_run_sequencer #(
    .REG_WIDTH(RW), .CORE_COUNT(CC),
    .DATA_MEM_ADDR_WIDTH(AW),
    .RX_END_LOC(7), .TX_START_LOC(5), .TX_END_LOC(8),
    .TIMEOUT_CYCLES(0),
    .CYCLE_WIDTH(CW), .RUN_CNT_WIDTH(NW)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  mc_run_sequencer #(
    .REG_WIDTH(RW), .CORE_COUNT(CC),
    .DATA_MEM_ADDR_WIDTH(AW),
    .RX_END_LOC(7), .TX_START_LOC(5), .TX_END_LOC(8),
    .TIMEOUT_CYCLES(50),
    .CYCLE_WIDTH(CW), .RUN_CNT_WIDTH(NW)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.start            = start;
  assign bus0.reload_ins       = reload_ins;
  assign bus0.ins_received     = ins_received;
  assign bus0.dmem_received    = dmem_received;
  assign bus0.dmem_transmitted = dmem_transmitted;
  assign bus0.proc_done        = proc_done;
  assign bus0.uart_dmem_wr_en  = wr_en;
  assign bus0.uart_dmem_addr   = wr_addr;
  assign bus0.uart_dmem_data   = wr_data;
  assign bus1.start            = start;
  assign bus1.reload_ins       = reload_ins;
  assign bus1.ins_received     = ins_received;
  assign bus1.dmem_received    = dmem_received;
  assign bus1.dmem_transmitted = dmem_transmitted;
  assign bus1.proc_done        = proc_done;
  assign bus1.uart_dmem_wr_en  = wr_en;
  assign bus1.uart_dmem_addr   = wr_addr;
  assign bus1.uart_dmem_data   = wr_data;

  // Observation mux: sel picks which DUT is checked.
  logic          sel = 1'b0;
  logic [2:0]    o_state;
  logic [1:0]    o_downer;
  logic          o_iowner, o_rxi, o_rxd, o_ps, o_txn;
  logic          o_terr, o_cerr;
  logic [RW-1:0] o_rx, o_txs, o_txe;
  logic [CW-1:0] o_cyc;
  logic [NW-1:0] o_runs;

  always_comb begin
    o_state  = sel ? bus1.state         : bus0.state;
    o_downer = sel ? bus1.dmem_owner    : bus0.dmem_owner;
    o_iowner = sel ? bus1.imem_owner    : bus0.imem_owner;
    o_rxi    = sel ? bus1.rx_ins_en     : bus0.rx_ins_en;
    o_rxd    = sel ? bus1.rx_dmem_en    : bus0.rx_dmem_en;
    o_ps     = sel ? bus1.proc_start    : bus0.proc_start;
    o_txn    = sel ? bus1.tx_startN     : bus0.tx_startN;
    o_terr   = sel ? bus1.timeout_err   : bus0.timeout_err;
    o_cerr   = sel ? bus1.cfg_err       : bus0.cfg_err;
    o_rx     = sel ? bus1.rx_end_addr   : bus0.rx_end_addr;
    o_txs    = sel ? bus1.tx_start_addr : bus0.tx_start_addr;
    o_txe    = sel ? bus1.tx_end_addr   : bus0.tx_end_addr;
    o_cyc    = sel ? bus1.run_cycles    : bus0.run_cycles;
    o_runs   = sel ? bus1.run_count     : bus0.run_count;
  end

  // Reference model state
  bit            m_ins_valid;
  int            m_runs;
  logic [RW-1:0] m_rx, m_txs, m_txe;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic set_sel(input bit s);
    sel = s;
    #1;
  endtask

  function automatic logic [2:0] entry_state(input bit rl);
    return (rl || !m_ins_valid) ? S_LIMEM : S_LDMEM;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ins_valid = 0;
    m_runs      = 0;
    m_rx        = '0;
    m_txs       = '0;
    m_txe       = '0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_state"}, o_state, S_IDLE);
    chk({p, "_downer"}, o_downer, 0);
    chk({p, "_iowner"}, o_iowner, 0);
    chk({p, "_rxi"}, o_rxi, 0);
    chk({p, "_rxd"}, o_rxd, 0);
    chk({p, "_pstart"}, o_ps, 0);
    chk({p, "_txn"}, o_txn, 1);
    chk({p, "_rx"}, o_rx, 0);
    chk({p, "_txs"}, o_txs, 0);
    chk({p, "_txe"}, o_txe, 0);
    chk({p, "_cyc"}, o_cyc, 0);
    chk({p, "_runs"}, o_runs, 0);
    chk({p, "_terr"}, o_terr, 0);
    chk({p, "_cerr"}, o_cerr, 0);
  endtask

  // Header write; acc says whether the loader accepts it.
  task automatic wr_hdr(input int addr,
                        input logic [DW-1:0] data,
                        input bit rcv, input bit acc);
    wr_en         = 1'b1;
    wr_addr       = AW'(addr);
    wr_data       = data;
    dmem_received = rcv;
    tick();
    wr_en         = 1'b0;
    dmem_received = 1'b0;
    if (acc) begin
      if (addr == 7) m_rx  = data[RW-1:0];
      if (addr == 5) m_txs = data[RW-1:0];
      if (addr == 8) m_txe = data[RW-1:0];
    end
  endtask

  task automatic full_run(input bit rl, input int ins_dly,
                          input int n_exec, input bit fixed);
    logic [2:0]    ent;
    logic [RW-1:0] a, b, t;
    logic [DW-1:0] d;
    ent = entry_state(rl);
    start = 1'b1; reload_ins = rl;
    tick();
    start = 1'b0; reload_ins = 1'b0;
    chk("entry", o_state, ent);
    if (ent == S_LIMEM) begin
      chk("imem_own_load", o_iowner, 1);
      chk("rx_ins_en", o_rxi, 1);
      repeat (ins_dly - 1) tick();
      chk("limem_hold", o_state, S_LIMEM);
      ins_received = 1'b1;
      tick();
      ins_received = 1'b0;
      m_ins_valid = 1;
    end else begin
      chk("imem_own_skip", o_iowner, 0);
    end
    chk("ldmem", o_state, S_LDMEM);
    chk("rx_dmem_en", o_rxd, 1);
    chk("dmem_own_uart", o_downer, 1);
    if (fixed) begin
      wr_hdr(5, DW'(12'h020), 0, 1);
      wr_hdr(8, DW'(12'h02F), 0, 1);
      wr_hdr(7, DW'(12'h01F), 1, 1);
    end else begin
      repeat ($urandom_range(1, 5)) begin
        d = {4'($urandom), $urandom};
        wr_hdr($urandom_range(0, 15), d, 0, 1);
      end
      a = RW'($urandom);
      b = RW'($urandom);
      if (a > b) begin t = a; a = b; b = t; end
      wr_hdr(5, {24'($urandom), a}, 0, 1);
      wr_hdr(8, {24'($urandom), b}, 1, 1);
    end
    chk("tx_start_addr", o_txs, m_txs);
    chk("tx_end_addr", o_txe, m_txe);
    chk("rx_end_addr", o_rx, m_rx);
    chk("exec", o_state, S_EXEC);
    chk("proc_start_hi", o_ps, 1);
    chk("dmem_own_proc", o_downer, 2);
    chk("cyc_clear", o_cyc, 0);
    tick();
    chk("proc_start_lo", o_ps, 0);
    repeat (n_exec - 2) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("tx_state", o_state, S_TX);
    chk("tx_startN_lo", o_txn, 0);
    chk("run_cycles", o_cyc, n_exec);
    tick();
    chk("tx_startN_hi", o_txn, 1);
    repeat ($urandom_range(0, 4)) tick();
    dmem_transmitted = 1'b1;
    tick();
    dmem_transmitted = 1'b0;
    m_runs++;
    chk("done", o_state, S_DONE);
    chk("run_count", o_runs, NW'(m_runs));
    chk("cyc_held", o_cyc, n_exec);
  endtask

  task automatic go_exec();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("go_limem", o_state, S_LIMEM);
    ins_received = 1'b1;
    tick();
    ins_received = 1'b0;
    m_ins_valid = 1;
    wr_hdr(5, DW'(12'h100), 0, 1);
    wr_hdr(8, DW'(12'h200), 1, 1);
    chk("go_exec", o_state, S_EXEC);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: run did not finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    do_reset();
    set_sel(0);
    chk_reset("rst0");
    set_sel(1);
    chk_reset("rst1");
    set_sel(0);

    // Directed first run, then re-runs
    full_run(0, 10, 100, 1);
    full_run(0, $urandom_range(2, 12),
             $urandom_range(2, 40), 0);
    full_run(1, $urandom_range(2, 12),
             $urandom_range(2, 40), 0);
    repeat (4)
      full_run(1'($urandom), $urandom_range(1, 12),
               $urandom_range(2, 60), 0);

    // Watchdog expiry
    do_reset();
    set_sel(1);
    go_exec();
    repeat (49) tick();
    chk("wd_cycle50", o_state, S_EXEC);
    chk("wd_cyc49", o_cyc, 49);
    tick();
    chk("wd_error", o_state, S_ERR);
    chk("wd_terr", o_terr, 1);
    chk("wd_cyc50", o_cyc, 50);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("err_sticky", o_state, S_ERR);
    do_reset();
    chk("wd_rst_state", o_state, S_IDLE);
    chk("wd_rst_terr", o_terr, 0);

    // Timeout boundary: done in the 50th cycle wins
    go_exec();
    repeat (49) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("wd_edge_tx", o_state, S_TX);
    chk("wd_edge_terr", o_terr, 0);
    chk("wd_edge_cyc", o_cyc, 50);

    // Bad window
    do_reset();
    set_sel(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    ins_received = 1'b1;
    tick();
    ins_received = 1'b0;
    wr_hdr(5, DW'(12'h030), 0, 1);
    wr_hdr(8, DW'(12'h010), 1, 1);
    chk("cfg_state", o_state, S_ERR);
    chk("cfg_err", o_cerr, 1);
    chk("cfg_no_pstart", o_ps, 0);
    tick();
    chk("cfg_no_pstart2", o_ps, 0);
    chk("cfg_rxd_off", o_rxd, 0);

    // Stray events and mid-run reset
    do_reset();
    go_exec();
    wr_hdr(5, DW'(12'h3AB), 0, 0);
    chk("stray_hdr", o_txs, m_txs);
    start = 1'b1; reload_ins = 1'b1;
    tick();
    start = 1'b0; reload_ins = 1'b0;
    chk("busy_start", o_state, S_EXEC);
    dmem_transmitted = 1'b1; ins_received = 1'b1;
    tick();
    dmem_transmitted = 1'b0; ins_received = 1'b0;
    chk("stray_pulse", o_state, S_EXEC);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("stray_tx", o_state, S_TX);
    chk("stray_txn_lo", o_txn, 0);
    do_reset();
    chk_reset("midrst");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_entry", o_state, entry_state(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
